// File: rtl/fir_coef_loader.sv
// -----------------------------------------------------------------------------
// fir_coef_loader
//   Host-side writer for the fir_filter coefficient shift port. Holds a local
//   bank of LEN coefficients behind a simple write/readback register port and,
//   on a start pulse, streams the bank into the filter as one contiguous burst
//   of LEN cfg_ce cycles, coefficient 0 first. In symmetric mode only the first
//   half of the bank is used and mirrored for the remaining taps.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   wr_en/addr/data     bank write port (rejected writes pulse wr_err)
//   rd_addr / rd_data   readback, 1-cycle latency, 0 for out-of-range
//   sym, start          burst request; sym sampled with start
//   busy, done          burst in progress / one-cycle completion pulse
//   wr_err              one-cycle pulse per rejected write
//   cfg_din, cfg_ce     coefficient stream to fir_filter
// -----------------------------------------------------------------------------
module fir_coef_loader #(
   parameter int LEN    = 21,
   parameter int COEF_W = 25,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [COEF_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [COEF_W-1:0] rd_data,
   input  logic              sym,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              wr_err,
   output logic [COEF_W-1:0] cfg_din,
   output logic              cfg_ce
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   // LEN fits in ADDR_W+1 bits since 2**ADDR_W >= LEN
   localparam logic [ADDR_W:0]   LEN_X = (ADDR_W+1)'(LEN);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LEN-1);
   localparam logic [ADDR_W-1:0] HALF  = ADDR_W'((LEN+1)/2);

   state_t            r_state;
   logic [COEF_W-1:0] r_bank [LEN];
   logic [ADDR_W-1:0] r_idx;
   logic              r_sym_q;

   logic              w_wr_ok;
   logic              w_wr_rej;
   logic              w_rd_ok;
   logic [ADDR_W-1:0] w_map;

   // Writes are blocked only while LOAD is walking the bank; DONE is safe
   // because the last coefficient has already been fetched.
   assign w_wr_ok  = wr_en && ({1'b0, wr_addr} < LEN_X) && (r_state != LOAD);
   assign w_wr_rej = wr_en && !w_wr_ok;
   assign w_rd_ok  = ({1'b0, rd_addr} < LEN_X);

   // Symmetric mode folds the upper taps back onto the lower half
   assign w_map = (r_sym_q && (r_idx >= HALF)) ? (LAST - r_idx) : r_idx;

   // Coefficient bank and readback
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < LEN; i++) r_bank[i] <= '0;
         rd_data <= '0;
      end else begin
         if (w_wr_ok) r_bank[wr_addr] <= wr_data;
         rd_data <= w_rd_ok ? r_bank[rd_addr] : '0;
      end
   end

   // Burst FSM with registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_sym_q <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wr_err  <= 1'b0;
         cfg_ce  <= 1'b0;
         cfg_din <= '0;
      end else begin
         wr_err  <= w_wr_rej;
         done    <= 1'b0;
         busy    <= 1'b0;
         cfg_ce  <= 1'b0;
         cfg_din <= '0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_sym_q <= sym;
                  r_idx   <= '0;
                  r_state <= LOAD;
               end
            end
            LOAD: begin
               // Bank write on the start edge has already landed here
               cfg_ce  <= 1'b1;
               busy    <= 1'b1;
               cfg_din <= r_bank[w_map];
               r_idx   <= r_idx + 1'b1;
               if (r_idx == LAST) r_state <= DONE;
            end
            DONE: begin
               done    <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
